// File: rtl/vgapatgen.sv
// ---------------------------------------------------------------------------
// vgapatgen: multi-mode VGA test-pattern source.
//
// Sits between the video timing generator and the pixel output path and
// follows the read/newline/newframe protocol. One pixel is produced for each
// accepted i_rd. The pixel is registered from the position held before the
// read, so o_pixel is valid one cycle after the i_rd edge and holds otherwise.
//
// Patterns (latched from i_mode at each i_newframe):
//   0 black, 1 colour bars, 2 scrolling bars, 3 checkerboard,
//   4 horizontal grey ramp, 5 vertical grey ramp, 6 solid i_solid, 7 RGB ramp.
// An optional 1-pixel white border overrides every pattern except black.
//
// Ports:
//   i_pixclk    pixel clock
//   i_reset_n   synchronous active-low reset
//   i_width     active pixels per line
//   i_height    active lines per frame
//   i_rd        pixel request, one pixel consumed per asserted cycle
//   i_newline   start of a new line
//   i_newframe  start of a new frame
//   i_mode      requested pattern, sampled at frame start
//   i_check_sh  checker square side = 2^(i_check_sh+2) pixels
//   i_solid     colour for the solid pattern, {R,G,B}
//   o_pixel     registered pixel, {R,G,B}
//   o_frame     16-bit frame counter
// ---------------------------------------------------------------------------
module vgapatgen #(
  parameter int BITS_PER_COLOR = 8,
  parameter int LGDIM          = 12,
  parameter int BORDER         = 1,
  parameter int SCROLL_SH      = 3
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset_n,
  input  logic [LGDIM-1:0]            i_width,
  input  logic [LGDIM-1:0]            i_height,
  input  logic                        i_rd,
  input  logic                        i_newline,
  input  logic                        i_newframe,
  input  logic [2:0]                  i_mode,
  input  logic [2:0]                  i_check_sh,
  input  logic [3*BITS_PER_COLOR-1:0] i_solid,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel,
  output logic [15:0]                 o_frame
);

  localparam int PW = 3 * BITS_PER_COLOR;
  localparam bit BORDER_EN = (BORDER != 0);
  localparam logic [BITS_PER_COLOR-1:0] CF = {BITS_PER_COLOR{1'b1}};
  localparam logic [BITS_PER_COLOR-1:0] CZ = '0;
  localparam logic [LGDIM-1:0] ONE = LGDIM'(1);

  // Colour-bar table: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [PW-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return {CF, CF, CF};
      3'd1:    return {CF, CF, CZ};
      3'd2:    return {CZ, CF, CF};
      3'd3:    return {CZ, CF, CZ};
      3'd4:    return {CF, CZ, CF};
      3'd5:    return {CF, CZ, CZ};
      3'd6:    return {CZ, CZ, CF};
      default: return {CZ, CZ, CZ};
    endcase
  endfunction

  // Position to colour component: truncate, or zero-extend when narrower.
  function automatic logic [BITS_PER_COLOR-1:0] pos_comp(input logic [LGDIM-1:0] v);
    return BITS_PER_COLOR'(v);
  endfunction

  function automatic logic [BITS_PER_COLOR-1:0] frm_comp(input logic [15:0] v);
    return BITS_PER_COLOR'(v);
  endfunction

  logic [LGDIM-1:0] hpos_q, hpos_d;
  logic [LGDIM-1:0] ypos_q, ypos_d;
  logic [LGDIM-1:0] hedge_q, hedge_d;
  logic [2:0]       bar_q, bar_d;
  logic [15:0]      frame_q, frame_d;
  logic [2:0]       mode_q, mode_d;
  logic             rd_seen_q, rd_seen_d;
  logic [PW-1:0]    pixel_q, pixel_d;

  logic [PW-1:0]    pix_c;
  logic [LGDIM-1:0] bar_step;
  logic [3:0]       ck_idx;
  logic [LGDIM-1:0] ck_h, ck_y;
  logic [2:0]       scroll_idx;
  logic             on_edge;
  logic [BITS_PER_COLOR-1:0] hcomp, ycomp;

  assign bar_step = i_width >> 3;

  // Pattern for the current (pre-increment) position.
  always_comb begin
    pix_c      = '0;
    ck_idx     = {1'b0, i_check_sh} + 4'd2;
    ck_h       = hpos_q >> ck_idx;
    ck_y       = ypos_q >> ck_idx;
    scroll_idx = bar_q + frame_q[SCROLL_SH+2:SCROLL_SH];
    hcomp      = pos_comp(hpos_q);
    ycomp      = pos_comp(ypos_q);
    on_edge    = (hpos_q == '0) || (hpos_q == i_width - ONE) ||
                 (ypos_q == '0) || (ypos_q == i_height - ONE);
    if ((hpos_q >= i_width) || (ypos_q >= i_height)) begin
      pix_c = '0;
    end else if (mode_q == 3'd0) begin
      pix_c = '0;
    end else if (BORDER_EN && on_edge) begin
      pix_c = '1;
    end else begin
      case (mode_q)
        3'd1:    pix_c = bar_color(bar_q);
        3'd2:    pix_c = bar_color(scroll_idx);
        3'd3:    pix_c = (ck_h[0] ^ ck_y[0]) ? '1 : '0;
        3'd4:    pix_c = {hcomp, hcomp, hcomp};
        3'd5:    pix_c = {ycomp, ycomp, ycomp};
        3'd6:    pix_c = i_solid;
        3'd7:    pix_c = {hcomp, ycomp, frm_comp(frame_q)};
        default: pix_c = '0;
      endcase
    end
  end

  // Next state: newframe > newline > rd. A read colliding with a line or
  // frame start is dropped, so the pixel holds.
  always_comb begin
    hpos_d    = hpos_q;
    ypos_d    = ypos_q;
    hedge_d   = hedge_q;
    bar_d     = bar_q;
    frame_d   = frame_q;
    mode_d    = mode_q;
    rd_seen_d = rd_seen_q;
    pixel_d   = pixel_q;
    if (i_newframe) begin
      ypos_d    = '0;
      frame_d   = frame_q + 16'd1;
      mode_d    = i_mode;
      rd_seen_d = 1'b0;
      if (i_newline) begin
        hpos_d  = '0;
        bar_d   = '0;
        hedge_d = bar_step;
      end
    end else if (i_newline) begin
      hpos_d    = '0;
      bar_d     = '0;
      hedge_d   = bar_step;
      rd_seen_d = 1'b0;
      // Blank lines (no reads) do not advance the line counter.
      if (rd_seen_q) ypos_d = ypos_q + ONE;
    end else if (i_rd) begin
      hpos_d    = hpos_q + ONE;
      rd_seen_d = 1'b1;
      pixel_d   = pix_c;
      if ((hpos_q >= hedge_q) && (bar_q != 3'd7)) begin
        bar_d   = bar_q + 3'd1;
        hedge_d = hedge_q + bar_step;
      end
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      hpos_q    <= '0;
      ypos_q    <= '0;
      hedge_q   <= bar_step;
      bar_q     <= '0;
      frame_q   <= '0;
      mode_q    <= '0;
      rd_seen_q <= 1'b0;
      pixel_q   <= '0;
    end else begin
      hpos_q    <= hpos_d;
      ypos_q    <= ypos_d;
      hedge_q   <= hedge_d;
      bar_q     <= bar_d;
      frame_q   <= frame_d;
      mode_q    <= mode_d;
      rd_seen_q <= rd_seen_d;
      pixel_q   <= pixel_d;
    end
  end

  assign o_pixel = pixel_q;
  assign o_frame = frame_q;

endmodule
